// File: rtl/scan_mux.sv
// rtl/scan_mux.sv - registered N-channel selector with direct and scan modes (optional scan: SCAN_MUX_SCAN_EN)
module scan_mux #(
    parameter int WIDTH = 1,
    parameter int NCH   = 3,
    parameter int SELW  = 2,
    parameter int DWELL = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   mode,
    input  logic [SELW-1:0]        sel_in,
    input  logic                   sel_vld,
    input  logic [NCH*WIDTH-1:0]   din,
    output logic [WIDTH-1:0]       y,
    output logic                   y_vld,
    output logic [SELW-1:0]        sel_cur,
    output logic                   sel_err,
    output logic                   scan_wrap
);

    // One extra bit so NCH == 2**SELW is representable in the range compare
    localparam logic [SELW:0]   NCH_W   = (SELW+1)'(NCH);
    localparam logic [SELW-1:0] LAST_CH = SELW'(NCH-1);

    logic [WIDTH-1:0] y_q, y_d;
    logic             y_vld_q, y_vld_d;
    logic [SELW-1:0]  sel_cur_q, sel_cur_d;
    logic             sel_err_q, sel_err_d;
    logic             sel_in_ok;

    // Range check of the requested channel; rejected requests never reach sel_cur
    assign sel_in_ok = ({1'b0, sel_in} < NCH_W);

    // Data path: present the channel selected before this edge
    always_comb begin
        y_d     = '0;
        y_vld_d = 1'b1;
        for (int k = 0; k < NCH; k++) begin
            if (sel_cur_q == SELW'(k)) begin
                y_d = din[k*WIDTH +: WIDTH];
            end
        end
    end

`ifdef SCAN_MUX_SCAN_EN
    localparam int             DCW        = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DCW-1:0] DWELL_LAST = DCW'(DWELL-1);

    logic [DCW-1:0] dwell_q, dwell_d;
    logic           scan_wrap_q, scan_wrap_d;

    // Select control: scan advances after DWELL edges per channel, direct takes only in-range requests
    always_comb begin
        sel_cur_d   = sel_cur_q;
        sel_err_d   = 1'b0;
        scan_wrap_d = 1'b0;
        dwell_d     = '0;
        if (mode) begin
            if (dwell_q == DWELL_LAST) begin
                dwell_d = '0;
                if (sel_cur_q == LAST_CH) begin
                    sel_cur_d   = '0;
                    scan_wrap_d = 1'b1;
                end else begin
                    sel_cur_d = sel_cur_q + SELW'(1);
                end
            end else begin
                dwell_d = dwell_q + DCW'(1);
            end
        end else if (sel_vld) begin
            if (sel_in_ok) begin
                sel_cur_d = sel_in;
            end else begin
                sel_err_d = 1'b1;
            end
        end
    end

    // Scan state registers; reset discards any wrap that was about to fire
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dwell_q     <= '0;
            scan_wrap_q <= 1'b0;
        end else begin
            dwell_q     <= dwell_d;
            scan_wrap_q <= scan_wrap_d;
        end
    end

    assign scan_wrap = scan_wrap_q;
`else
    logic unused_mode;
    assign unused_mode = mode;

    // Select control: direct mode only, out-of-range requests hold the channel
    always_comb begin
        sel_cur_d = sel_cur_q;
        sel_err_d = 1'b0;
        if (sel_vld) begin
            if (sel_in_ok) begin
                sel_cur_d = sel_in;
            end else begin
                sel_err_d = 1'b1;
            end
        end
    end

    assign scan_wrap = 1'b0;
`endif

    // Output and select registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            y_q       <= '0;
            y_vld_q   <= 1'b0;
            sel_cur_q <= '0;
            sel_err_q <= 1'b0;
        end else begin
            y_q       <= y_d;
            y_vld_q   <= y_vld_d;
            sel_cur_q <= sel_cur_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign y       = y_q;
    assign y_vld   = y_vld_q;
    assign sel_cur = sel_cur_q;
    assign sel_err = sel_err_q;

endmodule

// File: tb/tb_scan_mux.sv
// tb/tb_scan_mux.sv - directed table-driven bench for scan_mux
module tb_scan_mux;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       rst1_n;
    logic       mode;
    logic [1:0] sel_in;
    logic       sel_vld;
    logic [2:0] din;

    logic       y, y_vld, sel_err, scan_wrap;
    logic [1:0] sel_cur;
    logic       y1, y_vld1, sel_err1, scan_wrap1;
    logic [1:0] sel_cur1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    scan_mux #(.WIDTH(1), .NCH(3), .SELW(2), .DWELL(2)) dut (
        .clk(clk), .reset_n(reset_n), .mode(mode), .sel_in(sel_in), .sel_vld(sel_vld),
        .din(din), .y(y), .y_vld(y_vld), .sel_cur(sel_cur), .sel_err(sel_err),
        .scan_wrap(scan_wrap)
    );

    scan_mux #(.WIDTH(1), .NCH(3), .SELW(2), .DWELL(1)) dut1 (
        .clk(clk), .reset_n(rst1_n), .mode(mode), .sel_in(sel_in), .sel_vld(sel_vld),
        .din(din), .y(y1), .y_vld(y_vld1), .sel_cur(sel_cur1), .sel_err(sel_err1),
        .scan_wrap(scan_wrap1)
    );

    typedef struct {
        logic       mode;
        logic [1:0] sel_in;
        logic       sel_vld;
        logic [2:0] din;
        logic       y;
        logic [1:0] sel;
        logic       err;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic m, input logic [1:0] si, input logic sv, input logic [2:0] d);
        @(negedge clk);
        mode    = m;
        sel_in  = si;
        sel_vld = sv;
        din     = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] exp_s;
        logic [1:0] prev_s;
        logic [2:0] dv;

        tbl[0]  = '{1'b0, 2'd0, 1'b0, 3'b111, 1'b1, 2'd0, 1'b0};
        tbl[1]  = '{1'b0, 2'd2, 1'b1, 3'b100, 1'b0, 2'd2, 1'b0};
        tbl[2]  = '{1'b0, 2'd0, 1'b0, 3'b100, 1'b1, 2'd2, 1'b0};
        tbl[3]  = '{1'b0, 2'd0, 1'b0, 3'b011, 1'b0, 2'd2, 1'b0};
        tbl[4]  = '{1'b0, 2'd1, 1'b1, 3'b011, 1'b0, 2'd1, 1'b0};
        tbl[5]  = '{1'b0, 2'd3, 1'b1, 3'b011, 1'b1, 2'd1, 1'b1};
        tbl[6]  = '{1'b0, 2'd0, 1'b0, 3'b011, 1'b1, 2'd1, 1'b0};
        tbl[7]  = '{1'b0, 2'd3, 1'b1, 3'b010, 1'b1, 2'd1, 1'b1};
        tbl[8]  = '{1'b0, 2'd0, 1'b1, 3'b010, 1'b1, 2'd0, 1'b0};
        tbl[9]  = '{1'b0, 2'd2, 1'b0, 3'b101, 1'b1, 2'd0, 1'b0};
        tbl[10] = '{1'b0, 2'd0, 1'b0, 3'b101, 1'b1, 2'd0, 1'b0};
        tbl[11] = '{1'b0, 2'd2, 1'b1, 3'b110, 1'b0, 2'd2, 1'b0};
        tbl[12] = '{1'b0, 2'd0, 1'b0, 3'b110, 1'b1, 2'd2, 1'b0};

        reset_n = 1'b0;
        rst1_n  = 1'b0;
        mode    = 1'b0;
        sel_in  = 2'd0;
        sel_vld = 1'b0;
        din     = 3'b111;

        // Reset hold with all channels high
        @(posedge clk);
        #1;
        chk("rst y", y, 0);
        chk("rst y_vld", y_vld, 0);
        chk("rst sel_cur", sel_cur, 0);
        chk("rst sel_err", sel_err, 0);
        chk("rst scan_wrap", scan_wrap, 0);
        chk("rst1 y_vld", y_vld1, 0);

        @(negedge clk);
        reset_n = 1'b1;

        // Direct-mode vectors
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].mode, tbl[i].sel_in, tbl[i].sel_vld, tbl[i].din);
            chk($sformatf("vec%0d y", i), y, tbl[i].y);
            chk($sformatf("vec%0d y_vld", i), y_vld, 1);
            chk($sformatf("vec%0d sel_cur", i), sel_cur, tbl[i].sel);
            chk($sformatf("vec%0d sel_err", i), sel_err, tbl[i].err);
            chk($sformatf("vec%0d scan_wrap", i), scan_wrap, 0);
        end

`ifdef SCAN_MUX_SCAN_EN
        // Back to channel 0, then scan with DWELL=2 while a bad select is offered
        drive(1'b0, 2'd0, 1'b1, 3'b010);
        chk("pre-scan sel_cur", sel_cur, 0);
        prev_s = 2'd0;
        dv     = 3'b010;
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 2'd3, 1'b1, dv);
            exp_s = 2'((((i + 1) / 2) % 3));
            chk($sformatf("scan%0d sel_cur", i), sel_cur, exp_s);
            chk($sformatf("scan%0d y", i), y, dv[prev_s]);
            chk($sformatf("scan%0d sel_err", i), sel_err, 0);
            chk($sformatf("scan%0d scan_wrap", i), scan_wrap, (i == 5 || i == 11) ? 1 : 0);
            prev_s = exp_s;
        end

        // Leave scan mid-dwell: sel_cur freezes and the dwell counter clears
        drive(1'b1, 2'd0, 1'b0, dv);
        chk("middwell sel_cur", sel_cur, 0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 2'd0, 1'b0, dv);
            chk($sformatf("frz%0d sel_cur", i), sel_cur, 0);
            chk($sformatf("frz%0d scan_wrap", i), scan_wrap, 0);
        end
        drive(1'b1, 2'd0, 1'b0, dv);
        chk("rescan1 sel_cur", sel_cur, 0);
        drive(1'b1, 2'd0, 1'b0, dv);
        chk("rescan2 sel_cur", sel_cur, 1);
        drive(1'b0, 2'd0, 1'b0, dv);
        chk("exit sel_cur", sel_cur, 1);

        // DWELL=1 instance: reset while a wrap is pending
        @(negedge clk);
        mode   = 1'b1;
        rst1_n = 1'b1;
        @(posedge clk);
        #1;
        chk("d1 e1 sel_cur", sel_cur1, 1);
        chk("d1 e1 y_vld", y_vld1, 1);
        @(posedge clk);
        #1;
        chk("d1 e2 sel_cur", sel_cur1, 2);
        rst1_n = 1'b0;
        #1;
        chk("d1 async sel_cur", sel_cur1, 0);
        chk("d1 async y_vld", y_vld1, 0);
        chk("d1 async scan_wrap", scan_wrap1, 0);
        @(posedge clk);
        #1;
        chk("d1 held scan_wrap", scan_wrap1, 0);
        chk("d1 held sel_cur", sel_cur1, 0);
        @(negedge clk);
        rst1_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("d1 restart%0d sel_cur", i), sel_cur1, (i + 1) % 3);
            chk($sformatf("d1 restart%0d scan_wrap", i), scan_wrap1, (i == 2) ? 1 : 0);
            chk($sformatf("d1 restart%0d sel_err", i), sel_err1, 0);
        end
`else
        // Without scan support mode is ignored: sel_cur holds and no wrap appears
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 2'd0, 1'b0, 3'b110);
            chk($sformatf("noscan%0d sel_cur", i), sel_cur, 2);
            chk($sformatf("noscan%0d scan_wrap", i), scan_wrap, 0);
        end
        drive(1'b1, 2'd1, 1'b1, 3'b110);
        chk("noscan direct sel_cur", sel_cur, 1);
        drive(1'b1, 2'd3, 1'b1, 3'b110);
        chk("noscan bad sel_cur", sel_cur, 1);
        chk("noscan bad sel_err", sel_err, 1);
        chk("noscan bad y", y, 1);

        // DWELL=1 instance stays on channel 0 with mode high
        @(negedge clk);
        rst1_n  = 1'b1;
        sel_vld = 1'b0;
        din     = 3'b011;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("d1 noscan%0d sel_cur", i), sel_cur1, 0);
            chk($sformatf("d1 noscan%0d scan_wrap", i), scan_wrap1, 0);
            chk($sformatf("d1 noscan%0d y", i), y1, 1);
            chk($sformatf("d1 noscan%0d sel_err", i), sel_err1, 0);
            chk($sformatf("d1 noscan%0d y_vld", i), y_vld1, 1);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
